i4004_fetch: RTL and testbench

//  CPU-side bus sequencer of the MCS-4 core; sits directly upstream of the i4001 ROMs on the shared 4-bit bus.

---
 rtl/i4004_fetch.sv | 178 +++++++++++++++++
 tb/tb_i4004_fetch.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i4004_fetch.sv
// i4004_fetch
//   CPU-side bus sequencer of the MCS-4 core. Runs the 8-phase instruction
//   cycle (A1 A2 A3 M1 M2 X1 X2 X3), drives the PC onto the shared nibble
//   bus, fetches OPR/OPA and handles the two-word JUN, SRC chip select
//   and WRR/RDR ROM port I/O.
//
//   Handshake: there is no valid/ready back-pressure. instr_vld is a
//   one-cycle strobe in X1 and io_rdata_vld a one-cycle strobe in X3; the
//   consumer must take the data in that cycle.
//
// Ports
//   clk, rst          core clock (one bus phase per cycle), async active-high reset
//   dbus_in           wired-OR of all chip bus nibbles
//   dbus_out/dbus_oe  CPU bus nibble and ownership flag
//   sync              high in X3; the next cycle is A1
//   cm_rom, cl_rom    ROM command line and ROM I/O clear
//   instr_vld,opr,opa decoded instruction handed to the execute unit
//   src_addr, acc_in  SRC register pair / WRR accumulator, sampled in X1
//   io_rdata(_vld)    RDR result
//   pc                current instruction address
module i4004_fetch #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  dbus_in,
  output logic [3:0]  dbus_out,
  output logic        dbus_oe,
  output logic        sync,
  output logic        cm_rom,
  output logic        cl_rom,
  output logic        instr_vld,
  output logic [3:0]  opr,
  output logic [3:0]  opa,
  input  logic [7:0]  src_addr,
  input  logic [3:0]  acc_in,
  output logic [3:0]  io_rdata,
  output logic        io_rdata_vld,
  output logic [11:0] pc
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0, PH_A2 = 3'd1, PH_A3 = 3'd2, PH_M1 = 3'd3,
    PH_M2 = 3'd4, PH_X1 = 3'd5, PH_X2 = 3'd6, PH_X3 = 3'd7
  } phase_e;

  phase_e      phase_q, phase_d;
  logic [11:0] pc_q, pc_d;
  logic [3:0]  opr_q, opr_d;
  logic [3:0]  opa_q, opa_d;
  logic [7:0]  hold_q, hold_d;       // second word of JUN
  logic        jun_pend_q, jun_pend_d;
  logic        src_pend_q, src_pend_d;
  logic        wrr_pend_q, wrr_pend_d;
  logic        rdr_pend_q, rdr_pend_d;
  logic [7:0]  arg_q, arg_d;         // src_addr, or {0, acc_in} for WRR
  logic [3:0]  io_rdata_q, io_rdata_d;
  logic        cl_rom_q, cl_rom_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= PH_X3;
      pc_q       <= RESET_PC;
      opr_q      <= 4'h0;
      opa_q      <= 4'h0;
      hold_q     <= 8'h00;
      jun_pend_q <= 1'b0;
      src_pend_q <= 1'b0;
      wrr_pend_q <= 1'b0;
      rdr_pend_q <= 1'b0;
      arg_q      <= 8'h00;
      io_rdata_q <= 4'h0;
      cl_rom_q   <= 1'b1;
    end else begin
      phase_q    <= phase_d;
      pc_q       <= pc_d;
      opr_q      <= opr_d;
      opa_q      <= opa_d;
      hold_q     <= hold_d;
      jun_pend_q <= jun_pend_d;
      src_pend_q <= src_pend_d;
      wrr_pend_q <= wrr_pend_d;
      rdr_pend_q <= rdr_pend_d;
      arg_q      <= arg_d;
      io_rdata_q <= io_rdata_d;
      cl_rom_q   <= cl_rom_d;
    end
  end

  // Next-state logic
  always_comb begin
    phase_d    = phase_e'(phase_q + 3'd1);  // X3 wraps to A1
    pc_d       = pc_q;
    opr_d      = opr_q;
    opa_d      = opa_q;
    hold_d     = hold_q;
    jun_pend_d = jun_pend_q;
    src_pend_d = src_pend_q;
    wrr_pend_d = wrr_pend_q;
    rdr_pend_d = rdr_pend_q;
    arg_d      = arg_q;
    io_rdata_d = io_rdata_q;
    cl_rom_d   = 1'b0;
    case (phase_q)
      PH_M1: begin
        if (jun_pend_q) hold_d[7:4] = dbus_in;
        else            opr_d       = dbus_in;
      end
      PH_M2: begin
        if (jun_pend_q) hold_d[3:0] = dbus_in;
        else            opa_d       = dbus_in;
      end
      PH_X1: begin
        if (jun_pend_q) begin
          // opa still holds the first JUN word's low nibble
          pc_d       = {opa_q, hold_q};
          jun_pend_d = 1'b0;
        end else begin
          pc_d       = pc_q + 12'd1;
          jun_pend_d = (opr_q == 4'h4);
          src_pend_d = (opr_q == 4'h2) && opa_q[0];
          wrr_pend_d = (opr_q == 4'hE) && (opa_q == 4'h0);
          rdr_pend_d = (opr_q == 4'hE) && (opa_q == 4'hA);
          arg_d      = (opr_q == 4'hE) ? {4'h0, acc_in} : src_addr;
        end
      end
      PH_X2: begin
        if (rdr_pend_q) io_rdata_d = dbus_in;
      end
      PH_X3: begin
        src_pend_d = 1'b0;
        wrr_pend_d = 1'b0;
        rdr_pend_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Bus outputs, decoded from the registered phase and pending flags
  always_comb begin
    dbus_oe  = 1'b0;
    dbus_out = 4'h0;
    cm_rom   = 1'b0;
    case (phase_q)
      PH_A1: begin dbus_oe = 1'b1; dbus_out = pc_q[3:0];  end
      PH_A2: begin dbus_oe = 1'b1; dbus_out = pc_q[7:4];  end
      PH_A3: begin dbus_oe = 1'b1; dbus_out = pc_q[11:8]; end
      PH_M2: cm_rom = (opr_q == 4'hE) && !jun_pend_q;
      PH_X2: begin
        if (src_pend_q) begin
          dbus_oe  = 1'b1;
          dbus_out = arg_q[7:4];
          cm_rom   = 1'b1;
        end else if (wrr_pend_q) begin
          dbus_oe  = 1'b1;
          dbus_out = arg_q[3:0];
        end
      end
      PH_X3: begin
        if (src_pend_q) begin
          dbus_oe  = 1'b1;
          dbus_out = arg_q[3:0];
        end
      end
      default: ;
    endcase
  end

  assign sync         = (phase_q == PH_X3);
  assign instr_vld    = (phase_q == PH_X1) && !jun_pend_q;
  assign io_rdata_vld = (phase_q == PH_X3) && rdr_pend_q;
  assign opr          = opr_q;
  assign opa          = opa_q;
  assign pc           = pc_q;
  assign io_rdata     = io_rdata_q;
  assign cl_rom       = cl_rom_q;

endmodule

// File: tb/tb_i4004_fetch.sv
module tb_i4004_fetch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  dbus_in, dbus_out, opr, opa, acc_in, io_rdata;
  logic        dbus_oe, sync, cm_rom, cl_rom, instr_vld, io_rdata_vld;
  logic [7:0]  src_addr;
  logic [11:0] pc;

  i4004_fetch #(.RESET_PC(12'h000)) dut (
    .clk(clk), .rst(rst), .dbus_in(dbus_in), .dbus_out(dbus_out),
    .dbus_oe(dbus_oe), .sync(sync), .cm_rom(cm_rom), .cl_rom(cl_rom),
    .instr_vld(instr_vld), .opr(opr), .opa(opa), .src_addr(src_addr),
    .acc_in(acc_in), .io_rdata(io_rdata), .io_rdata_vld(io_rdata_vld), .pc(pc)
  );

  // second instance for PC wrap and mid-cycle reset; ROM returns NOPs
  logic        w_rst = 1'b1;
  logic [3:0]  w_dbus_out, w_opr, w_opa, w_io_rdata;
  logic        w_dbus_oe, w_sync, w_cm_rom, w_cl_rom, w_instr_vld, w_io_rdata_vld;
  logic [11:0] w_pc;

  i4004_fetch #(.RESET_PC(12'hFFE)) u_wrap (
    .clk(clk), .rst(w_rst), .dbus_in(4'h0), .dbus_out(w_dbus_out),
    .dbus_oe(w_dbus_oe), .sync(w_sync), .cm_rom(w_cm_rom), .cl_rom(w_cl_rom),
    .instr_vld(w_instr_vld), .opr(w_opr), .opa(w_opa), .src_addr(8'h00),
    .acc_in(4'h0), .io_rdata(w_io_rdata), .io_rdata_vld(w_io_rdata_vld), .pc(w_pc)
  );

  // ---------------- ROM model ----------------
  // Bench phase follows sync: the cycle after sync is A1.
  logic [7:0]  rom [0:4095];
  logic [2:0]  tb_ph;
  logic [11:0] cap_addr;
  logic        io_drive = 1'b0;
  logic [3:0]  io_val = 4'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) tb_ph <= 3'd0;
    else     tb_ph <= sync ? 3'd0 : tb_ph + 3'd1;
  end

  assign dbus_in = (tb_ph == 3'd3) ? rom[cap_addr][7:4] :
                   (tb_ph == 3'd4) ? rom[cap_addr][3:0] :
                   (tb_ph == 3'd6 && io_drive) ? io_val : 4'h0;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic        mon_en = 1'b0;
  logic [7:0]  exp_q[$];
  logic [11:0] addr_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (tb_ph == 3'd0) cap_addr[3:0] <= dbus_out;
      if (tb_ph == 3'd1) cap_addr[7:4] <= dbus_out;
      if (tb_ph == 3'd2) begin
        cap_addr[11:8] <= dbus_out;
        if (mon_en) begin
          checks++;
          if (addr_q.size() == 0) begin
            errors++;
            $display("FAIL addr: unexpected fetch at %h", {dbus_out, cap_addr[7:0]});
          end else begin
            logic [11:0] ea;
            ea = addr_q.pop_front();
            if ({dbus_out, cap_addr[7:0]} !== ea) begin
              errors++;
              $display("FAIL addr: got %h expected %h", {dbus_out, cap_addr[7:0]}, ea);
            end
          end
        end
      end
      if (mon_en && instr_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL instr: unexpected instr_vld opr=%h opa=%h", opr, opa);
        end else begin
          logic [7:0] ei;
          ei = exp_q.pop_front();
          if ({opr, opa} !== ei) begin
            errors++;
            $display("FAIL instr: got %h expected %h", {opr, opa}, ei);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_rom;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  // Returns at the negedge just after release; the DUT is in X3 there.
  task automatic apply_reset;
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: got %0d/%0d pending expected 0/0", name, exp_q.size(), addr_q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_reset;
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sync !== 1'b1)      begin errors++; $display("FAIL rst_sync: got %b expected 1", sync); end
    checks++; if (cl_rom !== 1'b1)    begin errors++; $display("FAIL rst_cl_rom: got %b expected 1", cl_rom); end
    checks++; if (cm_rom !== 1'b0)    begin errors++; $display("FAIL rst_cm_rom: got %b expected 0", cm_rom); end
    checks++; if (dbus_oe !== 1'b0)   begin errors++; $display("FAIL rst_oe: got %b expected 0", dbus_oe); end
    checks++; if (dbus_out !== 4'h0)  begin errors++; $display("FAIL rst_out: got %h expected 0", dbus_out); end
    checks++; if (instr_vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b expected 0", instr_vld); end
    checks++; if (pc !== 12'h000)     begin errors++; $display("FAIL rst_pc: got %h expected 000", pc); end
    checks++; if ({opr, opa} !== 8'h00) begin errors++; $display("FAIL rst_op: got %h expected 00", {opr, opa}); end
    checks++; if (io_rdata_vld !== 1'b0 || io_rdata !== 4'h0) begin
      errors++; $display("FAIL rst_io: got %b/%h expected 0/0", io_rdata_vld, io_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cl_rom !== 1'b0) begin errors++; $display("FAIL cl_rom_clear: got %b expected 0", cl_rom); end
  endtask

  task automatic test_nop_fetch;
    clear_rom();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      addr_q.push_back(12'(i));
      exp_q.push_back(8'h00);
    end
    for (int k = 0; k < 24; k++) begin
      int ph;
      src_addr = 8'($urandom_range(0, 255));
      acc_in   = 4'($urandom_range(0, 15));
      @(negedge clk);
      ph = k % 8;
      checks++;
      if (sync !== 1'(ph == 7)) begin errors++; $display("FAIL nop_sync k=%0d: got %b expected %b", k, sync, ph == 7); end
      checks++;
      if (dbus_oe !== 1'(ph < 3)) begin errors++; $display("FAIL nop_oe k=%0d: got %b expected %b", k, dbus_oe, ph < 3); end
      if (ph >= 3 && dbus_out !== 4'h0) begin
        checks++; errors++; $display("FAIL nop_out k=%0d: got %h expected 0", k, dbus_out);
      end
    end
    checks++; if (pc !== 12'h003) begin errors++; $display("FAIL nop_pc: got %h expected 003", pc); end
    check_drained("nop");
  endtask

  task automatic test_jun;
    clear_rom();
    rom[12'h000] = 8'h40;
    rom[12'h001] = 8'h25;
    apply_reset();
    addr_q.push_back(12'h000);
    addr_q.push_back(12'h001);
    addr_q.push_back(12'h025);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h00);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 13) begin
        checks++; if (instr_vld !== 1'b0) begin errors++; $display("FAIL jun_word2_vld: got %b expected 0", instr_vld); end
      end
      if (k == 14) begin
        checks++; if (pc !== 12'h025) begin errors++; $display("FAIL jun_pc: got %h expected 025", pc); end
      end
    end
    check_drained("jun");
  endtask

  task automatic test_src;
    clear_rom();
    rom[12'h000] = 8'h21;
    src_addr = 8'hC3;
    apply_reset();
    addr_q.push_back(12'h000);
    exp_q.push_back(8'h21);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 6) begin
        checks++;
        if ({dbus_oe, dbus_out, cm_rom} !== {1'b1, 4'hC, 1'b1}) begin
          errors++; $display("FAIL src_x2: got oe=%b out=%h cm=%b expected 1/c/1", dbus_oe, dbus_out, cm_rom);
        end
        src_addr = 8'h00;   // must not reach the bus any more
      end
      if (k == 7) begin
        checks++;
        if ({dbus_oe, dbus_out, cm_rom} !== {1'b1, 4'h3, 1'b0}) begin
          errors++; $display("FAIL src_x3: got oe=%b out=%h cm=%b expected 1/3/0", dbus_oe, dbus_out, cm_rom);
        end
      end
    end
    check_drained("src");
  endtask

  task automatic test_wrr;
    clear_rom();
    rom[12'h000] = 8'hE0;
    acc_in = 4'h5;
    apply_reset();
    addr_q.push_back(12'h000);
    exp_q.push_back(8'hE0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 3) begin checks++; if (cm_rom !== 1'b0) begin errors++; $display("FAIL wrr_m1_cm: got %b expected 0", cm_rom); end end
      if (k == 4) begin checks++; if (cm_rom !== 1'b1) begin errors++; $display("FAIL wrr_m2_cm: got %b expected 1", cm_rom); end end
      if (k == 6) begin
        checks++;
        if ({dbus_oe, dbus_out} !== {1'b1, 4'h5}) begin
          errors++; $display("FAIL wrr_x2: got oe=%b out=%h expected 1/5", dbus_oe, dbus_out);
        end
      end
      if (k == 7) begin
        checks++;
        if ({dbus_oe, dbus_out} !== {1'b0, 4'h0}) begin
          errors++; $display("FAIL wrr_x3: got oe=%b out=%h expected 0/0", dbus_oe, dbus_out);
        end
      end
    end
    check_drained("wrr");
  endtask

  task automatic test_rdr;
    clear_rom();
    rom[12'h000] = 8'hEA;
    io_drive = 1'b1;
    io_val   = 4'h9;
    apply_reset();
    addr_q.push_back(12'h000);
    addr_q.push_back(12'h001);
    exp_q.push_back(8'hEA);
    exp_q.push_back(8'h00);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 4) begin checks++; if (cm_rom !== 1'b1) begin errors++; $display("FAIL rdr_m2_cm: got %b expected 1", cm_rom); end end
      if (k == 6) begin
        checks++;
        if ({dbus_oe, io_rdata_vld} !== 2'b00) begin
          errors++; $display("FAIL rdr_x2: got oe=%b vld=%b expected 0/0", dbus_oe, io_rdata_vld);
        end
      end
      if (k == 7) begin
        checks++;
        if ({io_rdata_vld, io_rdata} !== {1'b1, 4'h9}) begin
          errors++; $display("FAIL rdr_x3: got vld=%b data=%h expected 1/9", io_rdata_vld, io_rdata);
        end
      end
      if (k == 8) begin
        checks++; if (io_rdata_vld !== 1'b0) begin errors++; $display("FAIL rdr_vld_pulse: got %b expected 0", io_rdata_vld); end
      end
    end
    io_drive = 1'b0;
    check_drained("rdr");
  endtask

  task automatic test_wrap;
    logic [11:0] exp_addr [0:2];
    logic [11:0] got;
    exp_addr[0] = 12'hFFE;
    exp_addr[1] = 12'hFFF;
    exp_addr[2] = 12'h000;
    got = 12'h000;
    @(negedge clk);
    w_rst = 1'b0;
    for (int k = 0; k < 29; k++) begin
      @(negedge clk);
      if (k % 8 == 0) got[3:0]  = w_dbus_out;
      if (k % 8 == 1) got[7:4]  = w_dbus_out;
      if (k % 8 == 2 && k < 24) begin
        got[11:8] = w_dbus_out;
        checks++;
        if (got !== exp_addr[k / 8]) begin
          errors++; $display("FAIL wrap_addr%0d: got %h expected %h", k / 8, got, exp_addr[k / 8]);
        end
      end
    end
    // now in M2 of the fourth cycle
    checks++; if (w_sync !== 1'b0) begin errors++; $display("FAIL wrap_pre_sync: got %b expected 0", w_sync); end
    w_rst = 1'b1;
    #1;
    checks++;
    if ({w_sync, w_pc, w_cl_rom, w_dbus_oe, w_instr_vld} !== {1'b1, 12'hFFE, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midrst: got sync=%b pc=%h cl=%b oe=%b vld=%b expected 1/ffe/1/0/0",
                         w_sync, w_pc, w_cl_rom, w_dbus_oe, w_instr_vld);
    end
    @(negedge clk);
    w_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({w_dbus_oe, w_dbus_out} !== {1'b1, 4'hE}) begin
      errors++; $display("FAIL midrst_a1: got oe=%b out=%h expected 1/e", w_dbus_oe, w_dbus_out);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    src_addr = 8'h00;
    acc_in   = 4'h0;
    cap_addr = 12'h000;
    clear_rom();
    test_reset();
    test_nop_fetch();
    test_jun();
    test_src();
    test_wrr();
    test_rdr();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
